// File: rtl/multi_pulse_generator_if.sv
// Control/status bundle for multi_pulse_generator. The slave side is the generator
// and the master side is the block that drives triggers and configuration.
interface multi_pulse_generator_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic                            en_i;
  logic [CHANNELS-1:0]             trigger_i;
  logic [CHANNELS-1:0]             retrig_i;
  logic [CHANNELS-1:0][CNT_W-1:0]  cfg_width_i;
  logic [CHANNELS-1:0]             clear_overrun_i;
  logic [CHANNELS-1:0]             pulse_o;
  logic [CHANNELS-1:0]             busy_o;
  logic [CHANNELS-1:0]             overrun_o;

  modport master (
    output en_i, trigger_i, retrig_i, cfg_width_i, clear_overrun_i,
    input  pulse_o, busy_o, overrun_o
  );

  modport slave (
    input  en_i, trigger_i, retrig_i, cfg_width_i, clear_overrun_i,
    output pulse_o, busy_o, overrun_o
  );
endinterface

// File: rtl/multi_pulse_generator.sv
// Multi-channel edge-triggered pulse generator with retrigger, post-pulse hold-off and
// sticky overrun. Define PULSE_GEN_SYNC_EN to add a 2-flop trigger synchroniser per lane.
module mpg_lane #(
  parameter int CNT_W = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             trig_i,
  input  logic             retrig_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic             clr_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             overrun_o
);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP);

  logic             trig_s, trig_q, rise, drop;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, gcnt_q;
  logic             pulse_q, busy_q, ovr_q;

`ifdef PULSE_GEN_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], trig_i};
  assign trig_s = sync_q[1];
`else
  assign trig_s = trig_i;
`endif

  // trig_q resets high so a level already high at reset release is not an edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) trig_q <= 1'b1;
    else        trig_q <= trig_s;

  assign rise = trig_s & ~trig_q;
  assign drop = en_i & rise & (((state_q == S_ACTIVE) & ~retrig_i) | (state_q == S_GAP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (!en_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise && width_i != '0) begin
            state_q <= S_ACTIVE;
            cnt_q   <= width_i;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_ACTIVE: begin
          // a reload on the terminal count wins, so the pulse extends without a gap
          if (rise && retrig_i) begin
            cnt_q <= (width_i == '0) ? ONE : width_i;
          end else if (cnt_q == ONE) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            if (GAP > 0) begin
              state_q <= S_GAP;
              gcnt_q  <= GAP_C;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        S_GAP: begin
          if (gcnt_q == ONE) begin
            state_q <= S_IDLE;
            gcnt_q  <= '0;
            busy_q  <= 1'b0;
          end else begin
            gcnt_q <= gcnt_q - ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          gcnt_q  <= '0;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // set beats clear; en does not gate clearing
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= drop | (ovr_q & ~clr_i);

  assign pulse_o   = pulse_q;
  assign busy_o    = busy_q;
  assign overrun_o = ovr_q;
endmodule

module multi_pulse_generator #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int GAP      = 0
) (
  input  logic clk,
  input  logic rst_n,
  multi_pulse_generator_if.slave bus
);
  logic [CHANNELS-1:0] pulse, busy, ovr;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    mpg_lane #(.CNT_W(CNT_W), .GAP(GAP)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (bus.en_i),
      .trig_i    (bus.trigger_i[g]),
      .retrig_i  (bus.retrig_i[g]),
      .width_i   (bus.cfg_width_i[g]),
      .clr_i     (bus.clear_overrun_i[g]),
      .pulse_o   (pulse[g]),
      .busy_o    (busy[g]),
      .overrun_o (ovr[g])
    );
  end

  assign bus.pulse_o   = pulse;
  assign bus.busy_o    = busy;
  assign bus.overrun_o = ovr;
endmodule

// File: tb/tb_multi_pulse_generator.sv
// Bench for multi_pulse_generator: two instances (GAP 0 and GAP 3) share stimulus and are
// checked against an end-time reference model, a vector table and directed sequences.
module tb_multi_pulse_generator;
  localparam int C  = 4;
  localparam int CW = 8;
`ifdef PULSE_GEN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   en;
  logic [C-1:0]           trig, retr, clr;
  logic [C-1:0][CW-1:0]   wid;

  multi_pulse_generator_if #(.CHANNELS(C), .CNT_W(CW)) ifa ();
  multi_pulse_generator_if #(.CHANNELS(C), .CNT_W(CW)) ifb ();

  assign ifa.en_i = en;  assign ifa.trigger_i = trig;  assign ifa.retrig_i = retr;
  assign ifa.cfg_width_i = wid;  assign ifa.clear_overrun_i = clr;
  assign ifb.en_i = en;  assign ifb.trigger_i = trig;  assign ifb.retrig_i = retr;
  assign ifb.cfg_width_i = wid;  assign ifb.clear_overrun_i = clr;

  multi_pulse_generator #(.CHANNELS(C), .CNT_W(CW), .GAP(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  multi_pulse_generator #(.CHANNELS(C), .CNT_W(CW), .GAP(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Model: per channel, the edge after which pulse / busy fall. Pulse is high after edge k iff k < act_end.
  int           k;
  int           act_end  [2][C];
  int           busy_end [2][C];
  logic [C-1:0] mov [2];
  logic [C-1:0] tsq, dly0, dly1;
  int           checks = 0, errors = 0;

  typedef struct {
    logic [C-1:0] trig;
    logic [C-1:0] exp_pulse_a;
    logic [C-1:0] exp_busy_b;
  } vec_t;
  vec_t tbl [14];

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic mdl_reset();
    k = 0;
    for (int d = 0; d < 2; d++) begin
      mov[d] = '0;
      for (int i = 0; i < C; i++) begin act_end[d][i] = 0; busy_end[d][i] = 0; end
    end
    tsq = '1; dly0 = '1; dly1 = '1;
  endtask

  task automatic mdl_edge();
    logic [C-1:0] ts, rise, setov;
    int w;
    k++;
    ts   = (LAT == 0) ? trig : dly1;
    dly1 = dly0;
    dly0 = trig;
    rise = ts & ~tsq;
    tsq  = ts;
    for (int d = 0; d < 2; d++) begin
      setov = '0;
      for (int i = 0; i < C; i++) begin
        w = int'(wid[i]);
        if (!en) begin
          act_end[d][i] = k; busy_end[d][i] = k;
        end else if (!(k - 1 < busy_end[d][i])) begin
          if (rise[i] && w != 0) begin
            act_end[d][i] = k + w; busy_end[d][i] = k + w + gap_of(d);
          end
        end else if (k - 1 < act_end[d][i]) begin
          if (rise[i]) begin
            if (retr[i]) begin
              act_end[d][i] = k + ((w == 0) ? 1 : w); busy_end[d][i] = act_end[d][i] + gap_of(d);
            end else setov[i] = 1'b1;
          end
        end else if (rise[i]) setov[i] = 1'b1;
      end
      mov[d] = setov | (mov[d] & ~clr);
    end
  endtask

  task automatic cmp(input string name, input logic [C-1:0] act, input logic [C-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [C-1:0] ep, eb;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < C; i++) begin
        ep[i] = (k < act_end[d][i]);
        eb[i] = (k < busy_end[d][i]);
      end
      cmp(d == 0 ? "mdl_a_pulse" : "mdl_b_pulse", d == 0 ? ifa.pulse_o : ifb.pulse_o, ep);
      cmp(d == 0 ? "mdl_a_busy" : "mdl_b_busy", d == 0 ? ifa.busy_o : ifb.busy_o, eb);
      cmp(d == 0 ? "mdl_a_ovr" : "mdl_b_ovr", d == 0 ? ifa.overrun_o : ifb.overrun_o, mov[d]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) mdl_edge(); else mdl_reset();
    @(negedge clk);
    compare_model();
  endtask

  task automatic steps(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic run_pat(input int ch, input logic [7:0] pat, input int n,
                         output int pa, output int ba, output int pb, output int bb);
    pa = 0; ba = 0; pb = 0; bb = 0;
    for (int s = 0; s < n; s++) begin
      trig[ch] = (s < 8) ? pat[s] : 1'b0;
      step();
      pa += int'(ifa.pulse_o[ch]); ba += int'(ifa.busy_o[ch]);
      pb += int'(ifb.pulse_o[ch]); bb += int'(ifb.busy_o[ch]);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_all();
    clr = '1; step(); clr = '0;
  endtask

  initial begin
    int pa, ba, pb, bb;
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1111, 4'b1111, 4'b1111};
    tbl[2] = '{4'b1111, 4'b1110, 4'b1111};
    tbl[3] = '{4'b1111, 4'b1100, 4'b1111};
    tbl[4] = '{4'b1111, 4'b1100, 4'b1111};
    tbl[5] = '{4'b1111, 4'b1100, 4'b1110};
    tbl[6] = '{4'b1111, 4'b1000, 4'b1100};
    tbl[7] = '{4'b1111, 4'b1000, 4'b1100};
    tbl[8] = '{4'b1111, 4'b1000, 4'b1100};
    tbl[9] = '{4'b1111, 4'b0000, 4'b1000};
    tbl[10] = '{4'b1111, 4'b0000, 4'b1000};
    tbl[11] = '{4'b1111, 4'b0000, 4'b1000};
    tbl[12] = '{4'b1111, 4'b0000, 4'b0000};
    tbl[13] = '{4'b1111, 4'b0000, 4'b0000};

    // reset with trigger[0] held high
    en = 1'b1; retr = '0; clr = '0; trig = 4'b0001;
    for (int i = 0; i < C; i++) wid[i] = 8'd3;
    mdl_reset();
    @(negedge clk);
    cmp("rst_pulse_a", ifa.pulse_o, '0);
    cmp("rst_busy_b", ifb.busy_o, '0);
    cmp("rst_ovr_a", ifa.overrun_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    steps(5);
    cmp("held_no_pulse", ifa.pulse_o, '0);
    cmp("held_no_ovr", ifa.overrun_o | ifb.overrun_o, '0);
    trig = '0;
    steps(3);
    run_pat(0, 8'hFF, 10, pa, ba, pb, bb);
    cmp_int("w3_pulse_a", pa, 3);
    cmp_int("w3_pulse_b", pb, 3);
    cmp_int("w3_busy_b", bb, 6);
    steps(4);

    // simultaneous edges, widths 1/2/5/8
    wid[0] = 8'd1; wid[1] = 8'd2; wid[2] = 8'd5; wid[3] = 8'd8;
    trig = '0;
    steps(4);
    for (int j = 0; j < 14; j++) begin
      trig = tbl[j].trig;
      step();
      if (j >= LAT) begin
        cmp("tbl_pulse_a", ifa.pulse_o, tbl[j-LAT].exp_pulse_a);
        cmp("tbl_busy_a", ifa.busy_o, tbl[j-LAT].exp_pulse_a);
        cmp("tbl_busy_b", ifb.busy_o, tbl[j-LAT].exp_busy_b);
      end
    end
    trig = '0;
    steps(12);

    // retrigger vs one-shot on channel 1, W = 4
    wid[1] = 8'd4; retr[1] = 1'b1;
    clear_all();
    run_pat(1, 8'b0000_0101, 16, pa, ba, pb, bb);
    cmp_int("retrig_pulse_a", pa, 6);
    cmp_int("retrig_pulse_b", pb, 6);
    cmp("retrig_no_ovr", (ifa.overrun_o | ifb.overrun_o) & 4'b0010, 4'b0000);
    retr[1] = 1'b0;
    run_pat(1, 8'b0000_0101, 16, pa, ba, pb, bb);
    cmp_int("oneshot_pulse_a", pa, 4);
    cmp_int("oneshot_pulse_b", pb, 4);
    cmp("oneshot_ovr", ifa.overrun_o & ifb.overrun_o & 4'b0010, 4'b0010);

    // hold-off on channel 2, W = 2
    wid[2] = 8'd2;
    clear_all();
    run_pat(2, 8'b0001_0001, 16, pa, ba, pb, bb);
    cmp_int("gap_pulse_b", pb, 2);
    cmp_int("gap_pulse_a", pa, 4);
    cmp("gap_ovr_b", ifb.overrun_o & 4'b0100, 4'b0100);
    cmp("gap_ovr_a", ifa.overrun_o & 4'b0100, 4'b0000);
    clear_all();
    cmp("clear_ovr_b", ifb.overrun_o, 4'b0000);
    for (int s = 0; s < 8; s++) begin
      trig[2] = (s == 0 || s == 2);
      clr[2]  = (s == 2 + LAT);
      step();
      if (s == 2 + LAT) cmp("set_beats_clear", ifa.overrun_o & ifb.overrun_o & 4'b0100, 4'b0100);
    end
    clr = '0; trig = '0;
    steps(8);
    run_pat(2, 8'b0000_0001, 12, pa, ba, pb, bb);
    cmp_int("after_gap_pulse_a", pa, 2);
    cmp_int("after_gap_pulse_b", pb, 2);
    cmp_int("after_gap_busy_b", bb, 5);

    // zero width on channel 3
    wid[3] = 8'd0;
    clear_all();
    run_pat(3, 8'b0000_0101, 10, pa, ba, pb, bb);
    cmp_int("w0_pulse", pa + pb, 0);
    cmp_int("w0_busy", ba + bb, 0);
    cmp("w0_no_ovr", (ifa.overrun_o | ifb.overrun_o) & 4'b1000, 4'b0000);

    // en dropped mid-pulse, no replay afterwards
    wid[0] = 8'd8; trig[0] = 1'b1;
    steps(3 + LAT);
    cmp("en_pre_pulse", ifa.pulse_o & ifb.pulse_o & 4'b0001, 4'b0001);
    en = 1'b0;
    step();
    cmp("en_off_pulse", ifa.pulse_o | ifb.pulse_o, 4'b0000);
    cmp("en_off_busy", ifa.busy_o | ifb.busy_o, 4'b0000);
    en = 1'b1;
    steps(6);
    cmp("en_no_replay", ifa.pulse_o | ifb.pulse_o, 4'b0000);

    // async reset mid-pulse clears pulse and overrun at once
    trig[0] = 1'b0; steps(2);
    trig[0] = 1'b1; step();
    trig[0] = 1'b0; step();
    trig[0] = 1'b1; step();
    trig[0] = 1'b0;
    steps(LAT + 1);
    cmp("pre_rst_pulse", ifa.pulse_o & 4'b0001, 4'b0001);
    cmp("pre_rst_ovr", ifa.overrun_o & 4'b0001, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_mid_pulse", ifa.pulse_o | ifb.pulse_o, 4'b0000);
    cmp("rst_mid_busy", ifa.busy_o | ifb.busy_o, 4'b0000);
    cmp("rst_mid_ovr", ifa.overrun_o | ifb.overrun_o, 4'b0000);
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
    steps(10);
    cmp("no_resume", ifa.pulse_o | ifb.pulse_o, 4'b0000);

    // randomized traffic against the model
    for (int s = 0; s < 800; s++) begin
      for (int i = 0; i < C; i++) begin
        if ($urandom_range(0, 2) == 0) trig[i] = ~trig[i];
        wid[i] = 8'($urandom_range(0, 6));
      end
      retr = C'($urandom);
      clr  = ($urandom_range(0, 7) == 0) ? C'($urandom) : '0;
      en   = ($urandom_range(0, 24) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
